// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The FIFO entry struct uses the package width constants, so the top-level
// ADDR_W/DATA_W parameters must match RF_ARB_ADDR_W/RF_ARB_DATA_W.
package rf_arb_pkg;

    localparam int RF_ARB_ADDR_W = 5;
    localparam int RF_ARB_DATA_W = 32;

    // IDLE: FIFO empty. PEND: loads buffered. FORCE: starved, stalling the core.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } rf_arb_state_e;

    // A buffered load return. A cleared live bit marks an entry whose write
    // has been superseded; it still occupies a slot until popped.
    typedef struct packed {
        logic                     live;
        logic [RF_ARB_ADDR_W-1:0] addr;
        logic [RF_ARB_DATA_W-1:0] data;
    } rf_arb_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Load-return skid FIFO: circular buffer with per-entry live bits and a
// kill-by-address port that clears the live bit of every matching entry.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rf_arb_entry_t            push_entry,
    input  logic                     pop,
    input  logic                     kill_valid,
    input  logic [RF_ARB_ADDR_W-1:0] kill_addr,
    output rf_arb_entry_t            head,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     empty
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    rf_arb_entry_t    mem [DEPTH];

    // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: a push writes its slot; otherwise a matching kill clears live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PTR_W'(i))) begin
                    mem[i] <= push_entry;
                end else if (kill_valid && (mem[i].addr == kill_addr)) begin
                    mem[i].live <= 1'b0;
                end
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. ALU writeback always wins; load returns
// go direct when the FIFO is empty and idle, otherwise are buffered and drained
// in ALU-free slots, with a stall request when starved or full.
// Optional feature macro: RF_ARB_KILL_EN (ALU write kills older queued loads
// to the same register).
//
// Handshake: a load return transfers on a cycle where ld_valid && ld_ready.
// ld_ready is !full from the registered count only, so a full FIFO refuses a
// load even when it pops in the same cycle. The ALU side has no ready.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int DATA_W     = RF_ARB_DATA_W,
    parameter  int ADDR_W     = RF_ARB_ADDR_W,
    parameter  int STARVE_MAX = 8,
    localparam int CNT_W      = $clog2(DEPTH) + 1,
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wr_valid,
    input  logic [ADDR_W-1:0] alu_wr_addr,
    input  logic [DATA_W-1:0] alu_wr_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_req,
    output logic [CNT_W-1:0]  fifo_count,
    output rf_arb_state_e     state_dbg
);

    logic              alu_go;
    logic              ld_killed;
    logic              ld_keep;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              kill_valid;
    logic [ADDR_W-1:0] kill_addr;
    rf_arb_entry_t     push_entry;
    rf_arb_entry_t     head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    rf_arb_state_e     state_q;
    rf_arb_state_e     state_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic              stall_d;

    // Writes to r0 are architecturally meaningless and never use the port.
    assign alu_go   = alu_wr_valid && (alu_wr_addr != '0);
    assign ld_ready = !full;

`ifdef RF_ARB_KILL_EN
    // A granted ALU write supersedes older loads to the same register,
    // including one arriving in the same cycle.
    assign kill_valid = alu_go;
    assign kill_addr  = alu_wr_addr;
    assign ld_killed  = alu_go && (ld_addr == alu_wr_addr);
`else
    assign kill_valid = 1'b0;
    assign kill_addr  = '0;
    assign ld_killed  = 1'b0;
`endif

    // An accepted load that still needs a write (nonzero, not superseded).
    assign ld_keep    = ld_valid && ld_ready && (ld_addr != '0) && !ld_killed;
    assign push_entry = '{live: 1'b1, addr: ld_addr, data: ld_data};

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_valid (kill_valid),
        .kill_addr  (kill_addr),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Grant mux: ALU, then FIFO head (dead heads burn the slot), then direct load.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = alu_wr_addr;
        wr_data = alu_wr_data;
        push    = 1'b0;
        pop     = 1'b0;
        if (alu_go) begin
            wr_en = 1'b1;
            push  = ld_keep;
        end else if (!empty) begin
            pop     = 1'b1;
            wr_en   = head.live;
            wr_addr = head.addr;
            wr_data = head.data;
            push    = ld_keep;
        end else if (ld_keep) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end
    end

    // Occupancy after this cycle's push/pop, used by the FSM and the stall.
    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Next-state logic with the starve counter; stall follows FORCE or a full FIFO.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                starve_d = '0;
                if (push) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (count_next == '0) begin
                    state_d  = ST_IDLE;
                    starve_d = '0;
                end else if (pop) begin
                    starve_d = '0;
                end else if (starve_q == STARVE_W'(STARVE_MAX - 1)) begin
                    state_d  = ST_FORCE;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ST_FORCE: begin
                starve_d = '0;
                if (count_next == '0) state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                starve_d = '0;
            end
        endcase
        stall_d = (state_d == ST_FORCE) || (count_next == CNT_W'(DEPTH));
    end

    // State, counter and registered write-port / stall outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            starve_q  <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            stall_req <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rf_we     <= wr_en;
            stall_req <= stall_d;
            if (wr_en) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
        end
    end

    assign fifo_count = count;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed testbench for rf_wr_arbiter: expected regfile writes are queued
// by the stimulus, a negedge monitor pops and compares every rf_we pulse.
module tb_rf_wr_arbiter;
    import rf_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_wr_valid;
    logic [4:0]  alu_wr_addr;
    logic [31:0] alu_wr_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [2:0]  fifo_count;
    rf_arb_state_e state_dbg;

    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;
    int          checks = 0;
    int          errors = 0;

    rf_wr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_req    (stall_req),
        .fifo_count   (fifo_count),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic idle_inputs;
        alu_wr_valid = 1'b0;
        alu_wr_addr  = '0;
        alu_wr_data  = '0;
        ld_valid     = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
    endtask

    // Scoreboard monitor: every regfile write must be the next expected one.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got r%0d=0x%0h, expected no write", rf_waddr, rf_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL rf_write: got r%0d=0x%0h expected r%0d=0x%0h",
                             rf_waddr, rf_wdata, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_stall", stall_req, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        step();

        // ALU write, then direct load, each one cycle to rf_we.
        expect_wr(5'd3, 32'h1234_5678);
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd3; alu_wr_data = 32'h1234_5678;
        step();
        idle_inputs();
        check("alu_latency_we", rf_we, 1);
        expect_wr(5'd4, 32'hAA);
        ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'hAA;
        step();
        idle_inputs();
        check("direct_ld_we", rf_we, 1);
        check("direct_ld_count", fifo_count, 0);
        step();

        // ALU every cycle plus 5 loads: 4 buffered, 5th refused; then drain.
        for (int i = 0; i < 5; i++) expect_wr(5'd5, 32'h500 + i);
        for (int k = 0; k < 4; k++) expect_wr(5'(6 + k), 32'h60 + k);
        for (int i = 0; i < 5; i++) begin
            alu_wr_valid = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'h500 + i;
            ld_valid = 1'b1; ld_addr = 5'(6 + i); ld_data = 32'h60 + i;
            if (i < 4) begin
                check($sformatf("fill_ld_ready_%0d", i), ld_ready, 1);
            end else begin
                check("full_ld_ready", ld_ready, 0);
                check("full_stall", stall_req, 1);
                check("full_count", fifo_count, 4);
            end
            step();
        end
        idle_inputs();
        check("full_after_refuse_count", fifo_count, 4);
        step();
        check("drain1_count", fifo_count, 3);
        check("drain1_stall", stall_req, 0);
        repeat (3) step();
        check("drained_count", fifo_count, 0);
        check("drained_ld_ready", ld_ready, 1);
        step();

        // Starvation: one queued load under continuous ALU writes.
        for (int i = 0; i < 10; i++) expect_wr(5'd11, 32'hB00 + i);
        expect_wr(5'd12, 32'hC12);
        for (int i = 0; i < 10; i++) begin
            alu_wr_valid = 1'b1; alu_wr_addr = 5'd11; alu_wr_data = 32'hB00 + i;
            ld_valid = (i == 0); ld_addr = 5'd12; ld_data = 32'hC12;
            step();
            check($sformatf("starve_stall_%0d", i), stall_req, (i >= 8) ? 1 : 0);
        end
        check("starve_count", fifo_count, 1);
        idle_inputs();
        step();
        check("forced_we", rf_we, 1);
        check("forced_waddr", rf_waddr, 12);
        check("forced_stall_drop", stall_req, 0);
        check("forced_count", fifo_count, 0);
        check("forced_state", state_dbg, ST_IDLE);
        step();

        // Older queued load vs younger ALU write to the same register.
        expect_wr(5'd5, 32'h55);
        expect_wr(5'd7, 32'h2);
`ifndef RF_ARB_KILL_EN
        expect_wr(5'd7, 32'h1);
`endif
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'h55;
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1;
        step();
        idle_inputs();
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd7; alu_wr_data = 32'h2;
        step();
        idle_inputs();
        step();
        check("kill_count", fifo_count, 0);
`ifdef RF_ARB_KILL_EN
        check("kill_dead_pop_we", rf_we, 0);
`else
        check("nokill_late_we", rf_we, 1);
`endif
        step();

        // r0 writes are dropped; a dropped ALU slot goes to the load.
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd0; alu_wr_data = 32'hDEAD;
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hBEEF;
        check("r0_ld_ready", ld_ready, 1);
        step();
        idle_inputs();
        check("r0_we", rf_we, 0);
        check("r0_count", fifo_count, 0);
        expect_wr(5'd13, 32'hD13);
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd0; alu_wr_data = 32'hDEAD;
        ld_valid = 1'b1; ld_addr = 5'd13; ld_data = 32'hD13;
        step();
        idle_inputs();
        check("r0_slot_we", rf_we, 1);
        check("r0_slot_waddr", rf_waddr, 13);
        step();

        // Asynchronous reset with 3 loads queued.
        for (int i = 0; i < 3; i++) expect_wr(5'd5, 32'h700 + i);
        for (int i = 0; i < 3; i++) begin
            alu_wr_valid = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'h700 + i;
            ld_valid = 1'b1; ld_addr = 5'(14 + i); ld_data = 32'hE0 + i;
            step();
        end
        idle_inputs();
        check("pre_rst_count", fifo_count, 3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_we", rf_we, 0);
        check("async_rst_waddr", rf_waddr, 0);
        check("async_rst_wdata", rf_wdata, 0);
        check("async_rst_stall", stall_req, 0);
        check("async_rst_count", fifo_count, 0);
        check("async_rst_ld_ready", ld_ready, 1);
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check("post_rst_count", fifo_count, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Register-file write-port arbiter and scheduler. Shares the core's single regfile write port between the execute-stage ALU writeback and the load unit's return path. ALU writes have fixed priority because the pipeline cannot stall them. Load returns are buffered in a small skid FIFO, drained in idle slots, and forced through with a pipeline stall request if starved.

## Interface
- DEPTH, 4, load-return FIFO entries; power of two, ≥2
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- STARVE_MAX, 8, consecutive non-draining cycles with FIFO non-empty before a forced drain
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_wr_valid  in  1  ALU writeback request; no ready, always granted
- alu_wr_addr  in  ADDR_W  ALU destination register
- alu_wr_data  in  DATA_W  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  load return accepted; `!full`, from registered state only
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- rf_we  out  1  regfile write enable, registered
- rf_waddr  out  ADDR_W  regfile write address, registered
- rf_wdata  out  DATA_W  regfile write data, registered
- stall_req  out  1  request to the core to hold issue, registered
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Per-cycle grant priority:
  1. ALU request with addr ≠ 0.
  2. FIFO head, if the entry is live.
  3. Load return, passed directly when the FIFO is empty.
- ALU request with addr 0: dropped. Its slot goes to the next priority level.
- Load return accepted (`ld_valid && ld_ready`) and not granted directly: pushed to the FIFO. Load with addr 0: accepted and discarded, never pushed.
- FIFO head with its live bit cleared: popped with no write (rf_we=0). This consumes the cycle's slot.
- State machine (encoding in package):
  - IDLE: FIFO empty. Go to PEND on a push.
  - PEND: FIFO non-empty. The starve counter increments each cycle the head is not popped and clears on each pop. When the counter reaches STARVE_MAX, go to FORCE. When the FIFO becomes empty, go to IDLE.
  - FORCE: stall_req=1. Go to IDLE when the FIFO becomes empty; stall_req deasserts the same edge.
- Full FIFO also asserts stall_req, in any state.
- Core contract: while stall_req is high, at most one further ALU write is in flight. ALU keeps priority regardless.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, fifo_count=0, state IDLE, starve counter 0, all live bits 0. After reset, ld_ready=1.
- Latency: ALU request to rf_we is 1 cycle. Direct load is 1 cycle. A buffered load writes at the earliest 1 cycle after its push cycle.
- ld_ready depends on registered count only. A full FIFO refuses a push even if a pop occurs the same cycle (no pop-through).
- Simultaneous ALU + load, FIFO empty: ALU writes and the load is pushed. Simultaneous ALU + load, FIFO full: ALU writes and ld_ready=0.
- Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
- Asynchronous reset mid-drain: FIFO contents are discarded and all outputs return to reset values immediately.

## Configuration
- RF_ARB_KILL_EN defined:
  - An ALU write granted to register X clears the live bit of every FIFO entry with addr X.
  - A load to X arriving in the same cycle is accepted but not pushed.
  - Rationale: the older load must not overwrite the younger ALU result.
- RF_ARB_KILL_EN undefined:
  - No kill logic. All accepted loads to a nonzero register are written in arrival order.
  - Software must avoid WAW between an outstanding load and a later ALU op.

## Structure
- Package rf_arb_pkg:
  - State enum (IDLE, PEND, FORCE).
  - Entry struct {live, addr, data}.
  - Width constants.
- Sub-module rf_arb_fifo: circular buffer with read/write pointers, count, per-entry live bits, and a kill-by-address port. The port is tied off when RF_ARB_KILL_EN is undefined.
- Top level holds the grant mux, the state machine, the starve counter, and the output registers.

## Test plan
- Reset, then ALU write r3=0x12345678 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0x12345678. Load r4=0xAA with FIFO empty and no ALU → written 1 cycle later.
- ALU write r5 each cycle plus 5 loads r6..r10 → 4 pushed, 5th sees ld_ready=0 and stall_req=1. ALU idle → r6..r9 drain in order, then fifo_count=0.
- Continuous ALU writes with 1 load queued → stall_req=1 exactly after 8 cycles (STARVE_MAX=8). Load written in the first ALU-free cycle; stall_req drops the same edge the FIFO empties.
- RF_ARB_KILL_EN: queue load r7=0x1, then ALU write r7=0x2 → no later write of 0x1 to r7. Without the macro → r7 is written 0x2, then 0x1.
- ALU and load writes to r0 → never appear on rf_we; FIFO count unchanged.
- Assert rst with 3 entries queued → outputs at reset values immediately; no queued entry is written after release.
